// File: rtl/mc_control_unit_hs.sv
// Multi-cycle RV32I control unit with req/ready bus handshakes, bus timeouts,
// a sticky trap state and a retired-instruction counter.
module mc_control_unit_hs #(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter bit SYS_AS_NOP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             imemReady,
  input  logic             busReady,
  output logic             imemReq,
  output logic             irWe,
  output logic             PCEn,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             busReq,
  output logic             busWe,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             trap,
  output logic [1:0]       trapCause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_LU  = 7'b0110111;
  localparam logic [6:0] OPC_AU  = 7'b0010111;
  localparam logic [6:0] OPC_J   = 7'b1101111;
  localparam logic [6:0] OPC_JL  = 7'b1100111;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_L   = 7'b0000011;
  localparam logic [6:0] OPC_FEN = 7'b0001111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_R_EXE, ST_I_EXE, ST_B_EXE, ST_LU_EXE, ST_AU_EXE,
    ST_J_EXE, ST_JL_EXE, ST_NOP_EXE, ST_S_EXE, ST_S_MEM, ST_L_EXE, ST_L_MEM,
    ST_L_WB, ST_TRAP
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause;
  logic [3:0]        op;
  logic              timeout_hit;
  logic              unused_bits;

  assign op          = {instrCode[30], instrCode[14:12]};
  assign timeout_hit = (BUS_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // The wait counter is zero outside the waiting states, so entering any of
  // them starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      cause    <= 2'b00;
      instret  <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_FETCH: begin
          if (imemReady) begin
            state <= ST_DECODE;
          end else if (timeout_hit) begin
            state <= ST_TRAP;
            cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          case (instrCode[6:0])
            OPC_R:   state <= ST_R_EXE;
            OPC_I:   state <= ST_I_EXE;
            OPC_B:   state <= ST_B_EXE;
            OPC_LU:  state <= ST_LU_EXE;
            OPC_AU:  state <= ST_AU_EXE;
            OPC_J:   state <= ST_J_EXE;
            OPC_JL:  state <= ST_JL_EXE;
            OPC_S:   state <= ST_S_EXE;
            OPC_L:   state <= ST_L_EXE;
            OPC_FEN, OPC_SYS: begin
              if (SYS_AS_NOP) begin
                state <= ST_NOP_EXE;
              end else begin
                state <= ST_TRAP;
                cause <= 2'b01;
              end
            end
            default: begin
              state <= ST_TRAP;
              cause <= 2'b01;
            end
          endcase
        end
        ST_R_EXE, ST_I_EXE, ST_B_EXE, ST_LU_EXE, ST_AU_EXE,
        ST_J_EXE, ST_JL_EXE, ST_NOP_EXE, ST_L_WB: begin
          state   <= ST_FETCH;
          instret <= instret + CNT_W'(1);
        end
        ST_S_EXE: state <= ST_S_MEM;
        ST_L_EXE: state <= ST_L_MEM;
        ST_S_MEM, ST_L_MEM: begin
          if (busReady) begin
            if (state == ST_S_MEM) begin
              state   <= ST_FETCH;
              instret <= instret + CNT_W'(1);
            end else begin
              state <= ST_L_WB;
            end
          end else if (timeout_hit) begin
            state <= ST_TRAP;
            cause <= 2'b11;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ST_TRAP;
      endcase
    end
  end

  always_comb begin
    imemReq       = 1'b0;
    irWe          = 1'b0;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    RFWDSrcMuxSel = 3'b000;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    trap          = 1'b0;
    trapCause     = cause;
    case (state)
      ST_FETCH: begin
        imemReq = 1'b1;
        irWe    = imemReady;
      end
      ST_R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = op;
        PCEn       = 1'b1;
      end
      ST_I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Only SRAI uses bit 30 as a function bit; elsewhere it is immediate.
        aluControl   = (op == 4'b1101) ? op : {1'b0, op[2:0]};
        PCEn         = 1'b1;
      end
      ST_B_EXE: begin
        branch     = 1'b1;
        aluControl = op;
        PCEn       = 1'b1;
      end
      ST_LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b010;
        PCEn          = 1'b1;
      end
      ST_AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b011;
        PCEn          = 1'b1;
      end
      ST_J_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        PCEn          = 1'b1;
      end
      ST_JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        jalr          = 1'b1;
        PCEn          = 1'b1;
      end
      ST_NOP_EXE: PCEn = 1'b1;
      ST_S_EXE:   aluSrcMuxSel = 1'b1;
      ST_S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busReq       = 1'b1;
        busWe        = 1'b1;
        PCEn         = busReady;
      end
      ST_L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
      end
      ST_L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        busReq        = 1'b1;
      end
      ST_L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        PCEn          = 1'b1;
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Randomized bench for mc_control_unit_hs: a per-instruction cycle-sequence
// model predicts every output on every cycle for two parameterizations.
module tb_mc_control_unit_hs;

  typedef struct packed {
    logic        imem_req, ir_we, pc_en, rf_we;
    logic [3:0]  alu;
    logic        alu_src, bus_req, bus_we;
    logic [2:0]  rfwd;
    logic        branch, jal, jalr, trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } outs_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        ir, br;
    outs_t       exp;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instr_code = '0;
  logic imem_ready = 1'b0;
  logic bus_ready = 1'b0;
  logic sel = 1'b0;

  logic a_imem_req, a_ir_we, a_pc_en, a_rf_we, a_alu_src, a_bus_req, a_bus_we;
  logic a_branch, a_jal, a_jalr, a_trap;
  logic [3:0] a_alu; logic [2:0] a_rfwd; logic [1:0] a_cause; logic [31:0] a_instret;
  logic b_imem_req, b_ir_we, b_pc_en, b_rf_we, b_alu_src, b_bus_req, b_bus_we;
  logic b_branch, b_jal, b_jalr, b_trap;
  logic [3:0] b_alu; logic [2:0] b_rfwd; logic [1:0] b_cause; logic [3:0] b_instret;

  always #5 clk = ~clk;

  mc_control_unit_hs #(.BUS_TIMEOUT(16), .CNT_W(32), .SYS_AS_NOP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .instrCode(instr_code), .imemReady(imem_ready),
    .busReady(bus_ready), .imemReq(a_imem_req), .irWe(a_ir_we), .PCEn(a_pc_en),
    .regFileWe(a_rf_we), .aluControl(a_alu), .aluSrcMuxSel(a_alu_src),
    .busReq(a_bus_req), .busWe(a_bus_we), .RFWDSrcMuxSel(a_rfwd), .branch(a_branch),
    .jal(a_jal), .jalr(a_jalr), .trap(a_trap), .trapCause(a_cause), .instret(a_instret));

  mc_control_unit_hs #(.BUS_TIMEOUT(4), .CNT_W(4), .SYS_AS_NOP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instrCode(instr_code), .imemReady(imem_ready),
    .busReady(bus_ready), .imemReq(b_imem_req), .irWe(b_ir_we), .PCEn(b_pc_en),
    .regFileWe(b_rf_we), .aluControl(b_alu), .aluSrcMuxSel(b_alu_src),
    .busReq(b_bus_req), .busWe(b_bus_we), .RFWDSrcMuxSel(b_rfwd), .branch(b_branch),
    .jal(b_jal), .jalr(b_jalr), .trap(b_trap), .trapCause(b_cause), .instret(b_instret));

  outs_t obs;
  always_comb begin
    obs = '0;
    if (!sel) begin
      obs.imem_req = a_imem_req; obs.ir_we = a_ir_we; obs.pc_en = a_pc_en;
      obs.rf_we = a_rf_we; obs.alu = a_alu; obs.alu_src = a_alu_src;
      obs.bus_req = a_bus_req; obs.bus_we = a_bus_we; obs.rfwd = a_rfwd;
      obs.branch = a_branch; obs.jal = a_jal; obs.jalr = a_jalr;
      obs.trap = a_trap; obs.cause = a_cause; obs.instret = a_instret;
    end else begin
      obs.imem_req = b_imem_req; obs.ir_we = b_ir_we; obs.pc_en = b_pc_en;
      obs.rf_we = b_rf_we; obs.alu = b_alu; obs.alu_src = b_alu_src;
      obs.bus_req = b_bus_req; obs.bus_we = b_bus_we; obs.rfwd = b_rfwd;
      obs.branch = b_branch; obs.jal = b_jal; obs.jalr = b_jalr;
      obs.trap = b_trap; obs.cause = b_cause; obs.instret = {28'd0, b_instret};
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Model configuration and architectural state.
  int              cfg_t;
  int              cfg_w;
  bit              cfg_nop;
  longint unsigned icnt;
  bit              trapped;
  logic [1:0]      tcause;
  entry_t          q[$];

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic outs_t base();
    outs_t o = '0;
    o.instret = icnt[31:0];
    o.trap    = trapped;
    o.cause   = tcause;
    return o;
  endfunction

  function automatic void push(input logic [31:0] ins, input logic ir, input logic br, input outs_t o);
    entry_t e;
    e.instr = ins; e.ir = ir; e.br = br; e.exp = o;
    q.push_back(e);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void commit();
    icnt = (icnt + 1) & ((64'd1 << cfg_w) - 1);
  endfunction

  // Appends the whole expected cycle sequence of one instruction given the
  // number of not-ready cycles the fetch and the data access will see.
  function automatic void model_instr(input logic [31:0] ins, input int fw, input int bw);
    outs_t      o;
    logic [6:0] opc = ins[6:0];
    logic [3:0] op  = {ins[30], ins[14:12]};
    bit         st  = (opc == 7'b0100011);
    if (trapped) return;
    for (int i = 0; i <= fw; i++) begin
      o = base(); o.imem_req = 1'b1; o.ir_we = (i == fw);
      push(ins, (i == fw), rb(), o);
      if (i != fw && cfg_t > 0 && i == cfg_t - 1) begin
        trapped = 1'b1; tcause = 2'b10; return;
      end
    end
    push(ins, rb(), rb(), base());
    o = base();
    case (opc)
      7'b0110011: begin o.rf_we = 1; o.alu = op; end
      7'b0010011: begin o.rf_we = 1; o.alu_src = 1; o.alu = (op == 4'hD) ? op : {1'b0, op[2:0]}; end
      7'b1100011: begin o.branch = 1; o.alu = op; end
      7'b0110111: begin o.rf_we = 1; o.rfwd = 3'd2; end
      7'b0010111: begin o.rf_we = 1; o.rfwd = 3'd3; end
      7'b1101111: begin o.rf_we = 1; o.rfwd = 3'd4; o.jal = 1; end
      7'b1100111: begin o.rf_we = 1; o.rfwd = 3'd4; o.jal = 1; o.jalr = 1; end
      7'b0001111, 7'b1110011: begin
        if (!cfg_nop) begin trapped = 1'b1; tcause = 2'b01; return; end
      end
      7'b0100011, 7'b0000011: begin
        o.alu_src = 1; o.rfwd = st ? 3'd0 : 3'd1;
        push(ins, rb(), rb(), o);
        for (int i = 0; i <= bw; i++) begin
          o = base(); o.alu_src = 1; o.bus_req = 1; o.bus_we = st;
          o.rfwd = st ? 3'd0 : 3'd1; o.pc_en = st && (i == bw);
          push(ins, rb(), (i == bw), o);
          if (i != bw && cfg_t > 0 && i == cfg_t - 1) begin
            trapped = 1'b1; tcause = 2'b11; return;
          end
        end
        if (st) begin commit(); return; end
        o = base(); o.rf_we = 1; o.alu_src = 1; o.rfwd = 3'd1;
      end
      default: begin trapped = 1'b1; tcause = 2'b01; return; end
    endcase
    o.pc_en = 1'b1;
    push(ins, rb(), rb(), o);
    commit();
  endfunction

  function automatic void model_tail(input int n);
    for (int i = 0; i < n; i++) push($urandom(), rb(), rb(), base());
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
                               7'b0010111, 7'b1101111, 7'b1100111, 7'b0100011,
                               7'b0000011, 7'b0001111, 7'b1110011, 7'b0000011};
    logic [31:0] x = $urandom();
    int          r = $urandom_range(0, 13);
    x[6:0] = (r < 12) ? opcs[r] : 7'($urandom());
    return x;
  endfunction

  function automatic int rwait();
    int r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 8) return $urandom_range(1, 3);
    return $urandom_range(0, (cfg_t > 0) ? cfg_t + 2 : 5);
  endfunction

  // Called at posedge+1; each entry is one clock cycle, checked at negedge.
  task automatic play(input int n);
    entry_t e;
    int k = 0;
    while (q.size() > 0 && k < n) begin
      e = q.pop_front();
      instr_code = e.instr; imem_ready = e.ir; bus_ready = e.br;
      @(negedge clk);
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL cycle @%0t instr=%h: got %h, expected %h", $time, e.instr, obs, e.exp);
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    icnt = 0; trapped = 1'b0; tcause = 2'b00; q.delete();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      model_instr(rand_instr(), rwait(), rwait());
      play(1000);
      if (trapped) begin
        model_tail(3);
        play(1000);
        do_reset();
      end
    end
  endtask

  initial begin
    int cnt_req, cnt_pc;
    logic [31:0] saved;

    // Configuration A: timeout 16, 32-bit counter, FENCE/SYSTEM as NOP.
    sel = 1'b0; cfg_t = 16; cfg_w = 32; cfg_nop = 1'b1;
    do_reset();
    check("reset_imemreq", {63'd0, obs.imem_req}, 64'd1);
    check("reset_instret", {32'd0, obs.instret}, 64'd0);

    model_instr(32'h003100B3, 0, 0);
    check("add_len", q.size(), 3);
    check("add_commit", {q[2].exp.pc_en, q[2].exp.rf_we, q[2].exp.alu}, {6'b110000});
    play(1000);
    check("add_instret", {32'd0, obs.instret}, 64'd1);

    model_instr(32'h4020D093, 0, 0);
    check("srai_alu", q[2].exp.alu, 4'b1101);
    play(1000);
    model_instr(32'h00209093, 0, 0);
    check("slli_alu", q[2].exp.alu, 4'b0001);
    play(1000);

    model_instr(32'h00012083, 0, 3);
    check("load_len", q.size(), 8);
    check("load_wb", {q[7].exp.rf_we, q[7].exp.rfwd}, {4'b1001});
    play(1000);

    model_instr(32'h0000000F, 0, 0);
    check("fence_len", q.size(), 3);
    play(1000);

    model_instr(32'h003100B3, 15, 0);
    check("fetch_edge_len", q.size(), 18);
    play(1000);
    check("fetch_edge_trap", {63'd0, obs.trap}, 64'd0);

    saved = obs.instret;
    model_instr(32'h00112023, 0, 100);
    cnt_req = 0; cnt_pc = 0;
    foreach (q[i]) begin
      cnt_req += int'(q[i].exp.bus_req);
      cnt_pc  += int'(q[i].exp.pc_en);
    end
    check("st_to_req_cycles", cnt_req, 16);
    check("st_to_pcen", cnt_pc, 0);
    model_tail(3);
    play(1000);
    check("st_to_cause", obs.cause, 2'b11);
    check("st_to_instret", obs.instret, saved);
    do_reset();

    model_instr(32'h0000007F, 0, 0);
    check("illegal_cause", tcause, 2'b01);
    model_tail(3);
    play(1000);
    do_reset();

    model_instr(32'h003100B3, 16, 0);
    check("fetch_to_cause", tcause, 2'b10);
    model_tail(3);
    play(1000);
    do_reset();

    random_run(150);

    // Asynchronous reset in the middle of a load's data wait.
    do_reset();
    model_instr(32'h003100B3, 0, 0);
    model_instr(32'h00012083, 0, 5);
    play(7);
    bus_ready = 1'b0;
    #2;
    check("mid_busreq_before", {63'd0, obs.bus_req}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_busreq_after", {63'd0, obs.bus_req}, 64'd0);
    check("mid_fetch", {63'd0, obs.imem_req}, 64'd1);
    check("mid_instret", {32'd0, obs.instret}, 64'd0);
    check("mid_trap", {63'd0, obs.trap}, 64'd0);
    @(posedge clk); #1;
    do_reset();

    // Configuration B: timeout 4, 4-bit counter, FENCE/SYSTEM illegal.
    sel = 1'b1; cfg_t = 4; cfg_w = 4; cfg_nop = 1'b0;
    do_reset();
    model_instr(32'h0000000F, 0, 0);
    check("fence_illegal", tcause, 2'b01);
    model_tail(3);
    play(1000);
    do_reset();

    for (int i = 0; i < 15; i++) model_instr(32'h003100B3, 0, 0);
    play(1000);
    check("pre_wrap", {32'd0, obs.instret}, 64'd15);
    model_instr(32'h003100B3, 0, 0);
    check("model_wrap", icnt, 64'd0);
    play(1000);
    check("wrap_instret", {32'd0, obs.instret}, 64'd0);

    random_run(120);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
